reduction_or_scanner: RTL

- Sequential counterpart to the 65-bit reduction-OR block; that block only reports whether any bit of the vector is set.
- This block accepts a 65-bit vector and enumerates the index of every set bit, lowest index first, one per handshake.
- It also reports the registered reduction OR and the population count of the loaded vector.
- Sits beside the reduction-OR datapath; consumers use it to find which request lines caused an asserted OR.

---
 rtl/reduction_or_scanner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reduction_or_scanner.sv
// Set-bit scanner: accepts a WIDTH-bit vector, reports its OR and popcount,
// then streams the index of every set bit, lowest first, over a valid/ready port.
//
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   gnd, vdd               supply rails, no logical function
//   clr                    synchronous abort back to IDLE
//   load_valid/ready/data  vector input handshake (ready only in IDLE)
//   any, ones              registered OR / popcount of last accepted vector
//   idx_valid/ready/idx    set-bit index output handshake
//   idx_last               current idx is the final set bit
//   done                   one-cycle pulse when a scan completes
module reduction_or_scanner #(
    parameter int WIDTH = 65,
    parameter int IDXW  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gnd,
    input  logic             vdd,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             any,
    output logic [IDXW-1:0]  ones,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDXW-1:0]  idx,
    output logic             idx_last,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              any_q, any_d;
    logic [IDXW-1:0]   ones_q, ones_d;
    logic              done_q, done_d;

    logic [IDXW-1:0]   ones_calc;
    logic [IDXW-1:0]   idx_enc;
    logic [WIDTH-1:0]  mask_low_cleared;

    // Rails exist only for netlist connectivity.
    logic rails_unused;
    assign rails_unused = gnd & vdd;

    // Popcount of the offered vector.
    always_comb begin
        ones_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_calc = ones_calc + IDXW'(load_data[i]);
        end
    end

    // Priority encode of the registered mask: lowest set bit wins.
    always_comb begin
        idx_enc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx_enc = IDXW'(i);
            end
        end
    end

    // m & (m-1) drops the lowest set bit; zero result means one bit was set.
    assign mask_low_cleared = mask_q & (mask_q - WIDTH'(1));

    assign idx        = idx_enc;
    assign idx_last   = (mask_q != '0) && (mask_low_cleared == '0);
    assign idx_valid  = (state_q == SCAN);
    assign load_ready = (state_q == IDLE);
    assign any        = any_q;
    assign ones       = ones_q;
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        any_d   = any_q;
        ones_d  = ones_q;
        done_d  = 1'b0;

        if (clr) begin
            state_d = IDLE;
            mask_d  = '0;
            any_d   = 1'b0;
            ones_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        mask_d = load_data;
                        any_d  = |load_data;
                        ones_d = ones_calc;
                        if (load_data != '0) begin
                            state_d = SCAN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx_ready) begin
                        mask_d = mask_low_cleared;
                        if (idx_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            any_q   <= 1'b0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            any_q   <= any_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

endmodule
